// File: rtl/led_pkg.sv
// Shared encodings for the LED brightness sequencer.
// Command mode codes, the sequencer state type and the default intensity width.
package led_pkg;

    localparam int unsigned LEVEL_W_DEF = 4;

    localparam logic [1:0] MODE_FADE    = 2'b00;
    localparam logic [1:0] MODE_BREATHE = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_SET     = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRamp,
        StHold,
        StBru,
        StBrd,
        StBlon,
        StBloff
    } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaled base tick plus a programmable step divider.
// Both counters restart from zero while clear is high.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned RATE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [RATE_W-1:0] rate,
    output logic              tick,
    output logic              step
);

    localparam int unsigned       PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  pre_q;
    logic [RATE_W-1:0] cnt_q;

    assign tick = (pre_q == PRE_MAX);
    assign step = tick && (cnt_q == rate);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                cnt_q <= step ? '0 : cnt_q + RATE_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_fade_ctrl.sv
// Brightness sequencer feeding the PWM duty input: fade, breathe, blink and set
// commands over valid/ready, stepping on a prescaled tick.
module led_fade_ctrl
    import led_pkg::*;
#(
    parameter int unsigned LEVEL_W  = LEVEL_W_DEF,
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned RATE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [LEVEL_W-1:0] cmd_target,
    input  logic [RATE_W-1:0]  cmd_rate,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic               done_q, done_d;
    logic               accept, clear, tick, step, adv;

    assign accept = cmd_valid && cmd_ready;
    // Counters sit in reset when nothing is stepping, and restart on every accept.
    assign clear  = accept || (state_q == StIdle) || (state_q == StHold);
    // An accept on the same edge as a step wins; the step is dropped.
    assign adv    = tick && step && !accept;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .RATE_W   (RATE_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .rate  (rate_q),
        .tick  (tick),
        .step  (step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            level_q  <= '0;
            target_q <= '0;
            rate_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        rate_d   = rate_q;
        done_d   = 1'b0;
        if (accept) begin
            target_d = cmd_target;
            rate_d   = cmd_rate;
            unique case (cmd_mode)
                MODE_SET: begin
                    level_d = cmd_target;
                    state_d = StHold;
                end
                MODE_FADE: begin
                    if (cmd_target == level_q) begin
                        state_d = StHold;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRamp;
                    end
                end
                MODE_BREATHE: begin
                    level_d = '0;
                    state_d = (cmd_target == '0) ? StHold : StBru;
                end
                MODE_BLINK: begin
                    level_d = cmd_target;
                    state_d = StBlon;
                end
            endcase
        end else if (adv) begin
            unique case (state_q)
                StRamp: begin
                    if (level_q < target_q) begin
                        level_d = level_q + LEVEL_W'(1);
                    end else if (level_q > target_q) begin
                        level_d = level_q - LEVEL_W'(1);
                    end
                    if (level_d == target_q) begin
                        state_d = StHold;
                        done_d  = 1'b1;
                    end
                end
                StBru: begin
                    if (level_q < target_q) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                    if (level_d == target_q) begin
                        state_d = StBrd;
                    end
                end
                StBrd: begin
                    if (level_q != '0) begin
                        level_d = level_q - LEVEL_W'(1);
                    end
                    if (level_d == '0) begin
                        state_d = StBru;
                    end
                end
                StBlon: begin
                    level_d = '0;
                    state_d = StBloff;
                end
                StBloff: begin
                    level_d = target_q;
                    state_d = StBlon;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state_q != StRamp);
        busy      = (state_q == StRamp);
    end

    assign level = level_q;
    assign done  = done_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl with TICK_DIV=4; level changes are scored
// against a queue of expected (observe-time, level) pairs.
module tb_led_fade_ctrl;
    import led_pkg::*;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_target;
    logic [3:0] cmd_rate;
    logic [3:0] level;
    logic       busy;
    logic       done;

    typedef struct {
        int         t;
        logic [3:0] lvl;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [3:0] prev_level;
    int         checks;
    int         failures;
    int         e;

    led_fade_ctrl #(
        .LEVEL_W  (4),
        .TICK_DIV (4),
        .RATE_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .level      (level),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int t, input logic [3:0] lvl);
        exp_t x;
        x.t   = t;
        x.lvl = lvl;
        sb_q.push_back(x);
    endtask

    // Called at a negedge; the command is taken on the following posedge.
    task automatic send(input logic [1:0] mode, input logic [3:0] tgt, input logic [3:0] rate);
        cmd_mode   = mode;
        cmd_target = tgt;
        cmd_rate   = rate;
        cmd_valid  = 1'b1;
        check("ready_before_send", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (int'($time) < t) @(negedge clk);
    endtask

    initial prev_level = '0;

    // Level-change monitor: every change must match the head of the scoreboard.
    always @(negedge clk) begin
        if (level !== prev_level) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", level, prev_level);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_level", level, mon_e.lvl);
                check("sb_time", int'($time), mon_e.t);
            end
            prev_level = level;
        end else if (sb_q.size() != 0 && sb_q[0].t <= int'($time)) begin
            mon_e = sb_q.pop_front();
            check("sb_missing", level, mon_e.lvl);
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = MODE_SET;
        cmd_target = '0;
        cmd_rate   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // FADE up to 5, rate 0
        e = int'($time) + 5;
        for (int k = 1; k <= 5; k++) push(e + 40 * k + 5, 4'(k));
        send(MODE_FADE, 4'd5, 4'd0);
        check("fade_busy", busy, 1);
        for (int i = 0; i < 20; i++) begin
            check("fade_ready_low", cmd_ready, 0);
            check("fade_done_low", done, 0);
            @(negedge clk);
        end
        check("fade_done_pulse", done, 1);
        check("fade_level", level, 5);
        check("fade_busy_end", busy, 0);
        check("fade_ready_end", cmd_ready, 1);
        @(negedge clk);
        check("fade_done_one", done, 0);

        // SET 12 then FADE down to 10 at rate 2, with a blocked command during RAMP
        e = int'($time) + 5;
        push(e + 5, 4'd12);
        send(MODE_SET, 4'd12, 4'd0);
        check("set_done_none", done, 0);
        e = int'($time) + 5;
        push(e + 125, 4'd11);
        push(e + 245, 4'd10);
        send(MODE_FADE, 4'd10, 4'd2);
        cmd_mode   = MODE_SET;
        cmd_target = 4'd0;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("ramp_blocked", cmd_ready, 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_to(e + 245);
        check("down_done", done, 1);
        check("down_level", level, 10);
        @(negedge clk);
        check("down_done_one", done, 0);
        check("down_hold_busy", busy, 0);

        // Degenerate fade to the current level
        send(MODE_FADE, 4'd10, 4'd3);
        check("degen_done", done, 1);
        check("degen_busy", busy, 0);
        check("degen_level", level, 10);
        @(negedge clk);
        check("degen_done_one", done, 0);

        // BREATHE 3, preempted by SET 7 on a step edge
        e = int'($time) + 5;
        push(e + 5, 4'd0);
        push(e + 45, 4'd1);
        push(e + 85, 4'd2);
        push(e + 125, 4'd3);
        push(e + 165, 4'd2);
        push(e + 205, 4'd1);
        push(e + 245, 4'd0);
        push(e + 285, 4'd1);
        send(MODE_BREATHE, 4'd3, 4'd0);
        wait_to(e + 315);
        push(e + 325, 4'd7);
        send(MODE_SET, 4'd7, 4'd0);
        wait_to(e + 405);
        check("preempt_level", level, 7);
        check("preempt_busy", busy, 0);
        check("preempt_ready", cmd_ready, 1);

        // BLINK 15 at rate 1, then BLINK 0
        e = int'($time) + 5;
        push(e + 5, 4'd15);
        push(e + 85, 4'd0);
        push(e + 165, 4'd15);
        push(e + 245, 4'd0);
        push(e + 325, 4'd15);
        send(MODE_BLINK, 4'd15, 4'd1);
        wait_to(e + 345);
        push(e + 355, 4'd0);
        send(MODE_BLINK, 4'd0, 4'd0);
        for (int i = 0; i < 64; i++) begin
            check("blink0_level", level, 0);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a ramp
        e = int'($time) + 5;
        push(e + 45, 4'd1);
        push(e + 85, 4'd2);
        send(MODE_FADE, 4'd15, 4'd0);
        wait_to(e + 95);
        push(e + 105, 4'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_level", level, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_level", level, 0);
        end

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
